// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, access size codes,
// the starvation limit default, and the alignment rule used by the lane generator.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_P_LOAD   = 2'd1,
    S_DBG_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int STARVE_MAX_DEF = 15;

  // Size code 2'b10 is not a legal encoding and is handled like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store lane generator: size/low address/right-aligned data -> byte enables,
// replicated write data and a misalignment flag. Lane layout assumes a 32-bit word.
module store_lane_gen
  import dmem_pkg::*;
#(
  parameter int B = 32
) (
  input  logic [1:0]   size,
  input  logic [1:0]   addr_lo,
  input  logic [B-1:0] wdata,
  output logic [3:0]   we,
  output logic [B-1:0] din,
  output logic         misaligned
);

  always_comb begin
    we         = 4'b0000;
    din        = wdata;
    misaligned = is_misaligned(size, addr_lo);
    case (size)
      SZ_BYTE: begin
        we  = 4'b0001 << addr_lo;
        din = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        we  = addr_lo[1] ? 4'b1100 : 4'b0011;
        din = {2{wdata[15:0]}};
      end
      default: begin
        we  = 4'b1111;
        din = wdata;
      end
    endcase
    // A misaligned store must not touch memory; the flag still reports it.
    if (misaligned) begin
      we = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: shares the memory between pipeline loads/stores and the
// debug port, stalls the pipeline for load latency and debug accesses, bounds debug starvation.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int B          = 32,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [5:0]        pipe_opcode,
  input  logic [B-1:0]      pipe_addr,
  input  logic [B-1:0]      pipe_wdata,
  output logic [B-1:0]      pipe_rdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [B-1:0]      dbg_wdata,
  output logic [B-1:0]      dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [B-1:0]      mem_din,
  input  logic [B-1:0]      mem_dout,
  output logic              misalign
);

  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  state_t      state, state_n;
  logic [3:0]  starve_cnt;
  logic        dbg_rd_q;
  logic [B-1:0] rdata_q;
  logic        pipe_gnt, dbg_gnt;

  logic [3:0]   lane_we;
  logic [B-1:0] lane_din;
  logic         lane_mis;

  logic unused_bits;
  assign unused_bits = ^{pipe_opcode[5:2], pipe_addr[B-1:ADDR_W+2]};

  store_lane_gen #(.B(B)) u_lanes (
    .size       (pipe_opcode[1:0]),
    .addr_lo    (pipe_addr[1:0]),
    .wdata      (pipe_wdata),
    .we         (lane_we),
    .din        (lane_din),
    .misaligned (lane_mis)
  );

  // Load data is the raw memory word; the MEM stage does lane extraction itself.
  assign pipe_rdata = mem_dout;

  // Read data is forwarded during the ack cycle and held from the register afterwards.
  assign dbg_rdata = (state == S_DBG_DONE && dbg_rd_q) ? mem_dout : rdata_q;

  always_comb begin
    state_n    = state;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    mem_addr   = pipe_addr[ADDR_W+1:2];
    mem_din    = lane_din;
    pipe_stall = 1'b0;
    dbg_ack    = 1'b0;
    pipe_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (dbg_req && (!pipe_req || starve_cnt == STARVE_C)) begin
          dbg_gnt    = 1'b1;
          mem_en     = 1'b1;
          mem_we     = dbg_we ? 4'b1111 : 4'b0000;
          mem_addr   = dbg_addr;
          mem_din    = dbg_wdata;
          pipe_stall = pipe_req;
          state_n    = S_DBG_DONE;
        end else if (pipe_req) begin
          pipe_gnt = 1'b1;
          mem_en   = 1'b1;
          if (pipe_we) begin
            mem_we = lane_we;
          end else begin
            pipe_stall = 1'b1;
            state_n    = S_P_LOAD;
          end
        end
      end
      S_P_LOAD: begin
        state_n = S_IDLE;
      end
      S_DBG_DONE: begin
        dbg_ack    = 1'b1;
        pipe_stall = pipe_req;
        state_n    = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    // Keep the memory and handshakes quiet for the whole reset pulse, not just after the edge.
    if (reset) begin
      mem_en     = 1'b0;
      mem_we     = 4'b0000;
      pipe_stall = 1'b0;
      dbg_ack    = 1'b0;
      pipe_gnt   = 1'b0;
      dbg_gnt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      dbg_rd_q   <= 1'b0;
      rdata_q    <= '0;
      misalign   <= 1'b0;
    end else begin
      if (state == S_DBG_DONE) begin
        starve_cnt <= 4'd0;
      end else if (pipe_gnt && dbg_req && starve_cnt != STARVE_C) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (dbg_gnt) begin
        dbg_rd_q <= !dbg_we;
      end
      if (state == S_DBG_DONE && dbg_rd_q) begin
        rdata_q <= mem_dout;
      end
      if (pipe_gnt && lane_mis) begin
        misalign <= 1'b1;
      end
    end
  end

endmodule
